stack_sequencer: RTL and testbench

Multi-cycle controller that sequences the memory stage's stack operations for interrupts, CALL, RET and RTI. It sits between decode/execute and the memory stage. It drives the memory stage's push/pop/pushPc/pushCCR/memRead/memWrite controls and stalls the front of the pipeline while a sequence runs. It returns the PC redirect and restored flags, and tracks stack depth to detect overflow and underflow.

---
 rtl/stack_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_stack_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// stack_sequencer: runs the multi-cycle stack sequences for interrupt entry,
// CALL, RET and RTI. It drives the memory-stage push/pop controls, stalls the
// front end while a sequence runs, and tracks stack depth for over/underflow.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting; chooses the next sequence (INT > RTI > RET > CALL)
// I_PC   | interrupt: push return PC
// I_CCR  | interrupt: push flags
// I_VEC  | interrupt: redirect to INT_VECTOR, acknowledge
// C_PC   | call: push return PC
// C_JMP  | call: redirect to the latched target
// R_PC   | ret: pop return PC
// R_LD   | ret: redirect to the popped PC
// T_CCR  | rti: pop flags
// T_PC   | rti: pop return PC
// T_LD   | rti: redirect and restore flags
module stack_sequencer #(
   parameter int          MAX_DEPTH  = 1024,
   parameter logic [15:0] INT_VECTOR = 16'h0000,
   localparam int         DW         = $clog2(MAX_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          int_req,
   input  logic          call_op,
   input  logic          ret_op,
   input  logic          rti_op,
   input  logic [15:0]   call_target,
   input  logic [15:0]   pc,
   input  logic [2:0]    flagReg,
   input  logic [15:0]   mem_rdata,
   output logic          push,
   output logic          pop,
   output logic          pushPc,
   output logic          pushCCR,
   output logic          memRead,
   output logic          memWrite,
   output logic          stall,
   output logic          pc_load,
   output logic [15:0]   pc_next,
   output logic          flag_load,
   output logic [2:0]    flags_out,
   output logic          int_ack,
   output logic          stack_err,
   output logic [DW-1:0] depth
);

   typedef enum logic [3:0] {
      S_IDLE, S_I_PC, S_I_CCR, S_I_VEC, S_C_PC, S_C_JMP,
      S_R_PC, S_R_LD, S_T_CCR, S_T_PC, S_T_LD
   } state_t;

   localparam logic [DW-1:0] INT_LIMIT  = DW'(MAX_DEPTH - 2);
   localparam logic [DW-1:0] CALL_LIMIT = DW'(MAX_DEPTH - 1);
   localparam logic [DW-1:0] DEPTH_MAX  = DW'(MAX_DEPTH);
   localparam logic [DW-1:0] ONE        = DW'(1);
   localparam logic [DW-1:0] TWO        = DW'(2);

   state_t        state_q, state_d;
   logic          pending_q, pending_d;
   logic [DW-1:0] depth_q, depth_d;
   logic          err_q, err_d;
   logic [15:0]   saved_pc_q, saved_pc_d;
   logic [2:0]    saved_ccr_q, saved_ccr_d;
   logic [15:0]   target_q, target_d;
   logic [15:0]   pc_reg_q, pc_reg_d;
   logic [2:0]    ccr_reg_q, ccr_reg_d;
   logic          int_live;

   // The return PC and flags are captured for the memory stage's write path,
   // which sources them itself; they are kept here for visibility only.
   logic unused_saved;
   assign unused_saved = ^{saved_pc_q, saved_ccr_q};

   // A request present this cycle counts as pending so it wins the same
   // IDLE decision it arrives in.
   assign int_live = pending_q | int_req;

   assign stack_err = err_q;
   assign depth     = depth_q;

   // State and datapath registers; reset aborts any sequence in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pending_q   <= 1'b0;
         depth_q     <= '0;
         err_q       <= 1'b0;
         saved_pc_q  <= '0;
         saved_ccr_q <= '0;
         target_q    <= '0;
         pc_reg_q    <= '0;
         ccr_reg_q   <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         depth_q     <= depth_d;
         err_q       <= err_d;
         saved_pc_q  <= saved_pc_d;
         saved_ccr_q <= saved_ccr_d;
         target_q    <= target_d;
         pc_reg_q    <= pc_reg_d;
         ccr_reg_q   <= ccr_reg_d;
      end
   end

   // Next-state, guard checks, depth tracking and per-state outputs.
   always_comb begin
      state_d     = state_q;
      pending_d   = int_live;
      depth_d     = depth_q;
      err_d       = err_q;
      saved_pc_d  = saved_pc_q;
      saved_ccr_d = saved_ccr_q;
      target_d    = target_q;
      pc_reg_d    = pc_reg_q;
      ccr_reg_d   = ccr_reg_q;
      push        = 1'b0;
      pop         = 1'b0;
      pushPc      = 1'b0;
      pushCCR     = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      stall       = 1'b1;
      pc_load     = 1'b0;
      pc_next     = '0;
      flag_load   = 1'b0;
      flags_out   = '0;
      int_ack     = 1'b0;

      case (state_q)
         S_IDLE: begin
            stall = 1'b0;
            if (!rst) begin
               if (int_live) begin
                  if (depth_q <= INT_LIMIT) begin
                     stall       = 1'b1;
                     state_d     = S_I_PC;
                     saved_pc_d  = pc;
                     saved_ccr_d = flagReg;
                  end else begin
                     err_d     = 1'b1;
                     pending_d = 1'b0;
                  end
               end else if (rti_op) begin
                  if (depth_q >= TWO) begin
                     stall   = 1'b1;
                     state_d = S_T_CCR;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (ret_op) begin
                  if (depth_q >= ONE) begin
                     stall   = 1'b1;
                     state_d = S_R_PC;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (call_op) begin
                  if (depth_q <= CALL_LIMIT) begin
                     stall      = 1'b1;
                     state_d    = S_C_PC;
                     saved_pc_d = pc;
                     target_d   = call_target;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
         end
         S_I_PC: begin
            push     = 1'b1;
            pushPc   = 1'b1;
            memWrite = 1'b1;
            state_d  = S_I_CCR;
         end
         S_I_CCR: begin
            push     = 1'b1;
            pushCCR  = 1'b1;
            memWrite = 1'b1;
            state_d  = S_I_VEC;
         end
         S_I_VEC: begin
            pc_load   = 1'b1;
            pc_next   = INT_VECTOR;
            int_ack   = 1'b1;
            pending_d = 1'b0;
            state_d   = S_IDLE;
         end
         S_C_PC: begin
            push     = 1'b1;
            pushPc   = 1'b1;
            memWrite = 1'b1;
            state_d  = S_C_JMP;
         end
         S_C_JMP: begin
            pc_load = 1'b1;
            pc_next = target_q;
            state_d = S_IDLE;
         end
         S_R_PC: begin
            pop      = 1'b1;
            memRead  = 1'b1;
            pc_reg_d = mem_rdata;
            state_d  = S_R_LD;
         end
         S_R_LD: begin
            pc_load = 1'b1;
            pc_next = pc_reg_q;
            state_d = S_IDLE;
         end
         S_T_CCR: begin
            pop       = 1'b1;
            memRead   = 1'b1;
            ccr_reg_d = mem_rdata[2:0];
            state_d   = S_T_PC;
         end
         S_T_PC: begin
            pop      = 1'b1;
            memRead  = 1'b1;
            pc_reg_d = mem_rdata;
            state_d  = S_T_LD;
         end
         S_T_LD: begin
            pc_load   = 1'b1;
            flag_load = 1'b1;
            pc_next   = pc_reg_q;
            flags_out = ccr_reg_q;
            state_d   = S_IDLE;
         end
         default: begin
            stall   = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      // Guards make these saturations unreachable; they only keep depth
      // from ever wrapping.
      if (push && depth_q != DEPTH_MAX) depth_d = depth_q + ONE;
      if (pop && depth_q != '0)         depth_d = depth_q - ONE;
   end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: a stack-of-words reference model decides each
// operation's guard outcome, pushed/popped values and expected control
// waveform; the DUT is compared cycle by cycle.
module tb_stack_sequencer;

   localparam int MAX_DEPTH = 1024;
   localparam int K_INT = 0, K_CALL = 1, K_RET = 2, K_RTI = 3;

   // {push,pop,pushPc,pushCCR,memRead,memWrite,stall,pc_load,flag_load,int_ack}
   localparam logic [9:0] V_START = 10'b0000001000;
   localparam logic [9:0] V_PSHPC = 10'b1010011000;
   localparam logic [9:0] V_PSHCC = 10'b1001011000;
   localparam logic [9:0] V_INTLD = 10'b0000001101;
   localparam logic [9:0] V_JMP   = 10'b0000001100;
   localparam logic [9:0] V_POP   = 10'b0100101000;
   localparam logic [9:0] V_RTILD = 10'b0000001110;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        int_req = 1'b0, call_op = 1'b0, ret_op = 1'b0, rti_op = 1'b0;
   logic [15:0] call_target = '0, pc = '0, mem_rdata = '0;
   logic [2:0]  flagReg = '0;
   logic        push, pop, pushPc, pushCCR, memRead, memWrite, stall;
   logic        pc_load, flag_load, int_ack, stack_err;
   logic [15:0] pc_next;
   logic [2:0]  flags_out;
   logic [10:0] depth;
   logic [9:0]  obs;

   logic [15:0] model_q[$];
   bit          model_err = 1'b0;
   int          checks_total = 0;
   int          checks_passed = 0;

   assign obs = {push, pop, pushPc, pushCCR, memRead, memWrite, stall,
                 pc_load, flag_load, int_ack};

   stack_sequencer #(.MAX_DEPTH(MAX_DEPTH), .INT_VECTOR(16'h0000)) dut (
      .clk(clk), .rst(rst), .int_req(int_req), .call_op(call_op),
      .ret_op(ret_op), .rti_op(rti_op), .call_target(call_target), .pc(pc),
      .flagReg(flagReg), .mem_rdata(mem_rdata), .push(push), .pop(pop),
      .pushPc(pushPc), .pushCCR(pushCCR), .memRead(memRead),
      .memWrite(memWrite), .stall(stall), .pc_load(pc_load),
      .pc_next(pc_next), .flag_load(flag_load), .flags_out(flags_out),
      .int_ack(int_ack), .stack_err(stack_err), .depth(depth)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish, passed %0d of %0d", checks_passed, checks_total);
      $fatal(1, "timeout");
   end

   // Runs one operation from an IDLE cycle and checks every cycle of it.
   // hold_call keeps call_op asserted through the sequence (conflict case).
   task automatic exec_op(input int kind, input logic [15:0] a_pc,
                          input logic [15:0] a_tgt, input logic [2:0] a_flg,
                          input bit hold_call);
      bit          ok;
      int          n;
      int          d0;
      logic [9:0]  ev[4];
      logic [15:0] epc[4];
      logic [2:0]  efl[4];
      logic [15:0] rd[4];
      int          edep[4];
      bit          eerr;
      logic [15:0] top;
      string       nm;
      d0 = model_q.size();
      for (int k = 0; k < 4; k++) begin
         ev[k] = '0; epc[k] = '0; efl[k] = '0; rd[k] = 16'($urandom);
      end
      case (kind)
         K_INT:   begin ok = (d0 <= MAX_DEPTH - 2); nm = "int";  end
         K_CALL:  begin ok = (d0 <= MAX_DEPTH - 1); nm = "call"; end
         K_RET:   begin ok = (d0 >= 1);             nm = "ret";  end
         default: begin ok = (d0 >= 2);             nm = "rti";  end
      endcase
      eerr = model_err;
      n = 1;
      if (!ok) begin
         model_err = 1'b1;
      end else begin
         case (kind)
            K_INT: begin
               n = 4;
               ev[0] = V_START; ev[1] = V_PSHPC; ev[2] = V_PSHCC; ev[3] = V_INTLD;
               epc[3] = 16'h0000;
               model_q.push_back(a_pc);
               model_q.push_back({13'b0, a_flg});
            end
            K_CALL: begin
               n = 3;
               ev[0] = V_START; ev[1] = V_PSHPC; ev[2] = V_JMP;
               epc[2] = a_tgt;
               model_q.push_back(a_pc);
            end
            K_RET: begin
               n = 3;
               ev[0] = V_START; ev[1] = V_POP; ev[2] = V_JMP;
               rd[1] = model_q.pop_back();
               epc[2] = rd[1];
            end
            default: begin
               n = 4;
               ev[0] = V_START; ev[1] = V_POP; ev[2] = V_POP; ev[3] = V_RTILD;
               rd[1] = model_q.pop_back();
               rd[2] = model_q.pop_back();
               top = rd[1];
               efl[3] = top[2:0];
               epc[3] = rd[2];
            end
         endcase
      end
      edep[0] = d0;
      for (int k = 1; k < 4; k++)
         edep[k] = edep[k-1] + int'(ev[k-1][9]) - int'(ev[k-1][8]);

      case (kind)
         K_INT:   begin int_req = 1'b1; pc = a_pc; flagReg = a_flg; end
         K_CALL:  begin call_op = 1'b1; call_target = a_tgt; pc = a_pc; end
         K_RET:   ret_op = 1'b1;
         default: rti_op = 1'b1;
      endcase
      if (hold_call) begin
         call_op = 1'b1;
         call_target = a_tgt;
      end

      for (int k = 0; k < n; k++) begin
         mem_rdata = rd[k];
         @(negedge clk);
         checks_total += 4;
         if (obs !== ev[k])
            $display("FAIL %s c%0d ctrl: got %b want %b", nm, k, obs, ev[k]);
         else checks_passed++;
         if (pc_next !== epc[k] || flags_out !== efl[k])
            $display("FAIL %s c%0d redirect: got pc_next=%h flags=%b want %h %b", nm, k, pc_next, flags_out, epc[k], efl[k]);
         else checks_passed++;
         if (depth !== 11'(edep[k]))
            $display("FAIL %s c%0d depth: got %0d want %0d", nm, k, depth, edep[k]);
         else checks_passed++;
         if (stack_err !== eerr)
            $display("FAIL %s c%0d stack_err: got %b want %b", nm, k, stack_err, eerr);
         else checks_passed++;
         @(posedge clk);
         #1;
         if (k == 0) begin
            int_req = 1'b0; rti_op = 1'b0; ret_op = 1'b0;
            if (!hold_call) call_op = 1'b0;
            pc = 16'($urandom); flagReg = 3'($urandom);
         end
      end

      if (!hold_call) begin
         mem_rdata = 16'($urandom);
         @(negedge clk);
         checks_total += 3;
         if (obs !== 10'b0)
            $display("FAIL %s idle ctrl: got %b want %b", nm, obs, 10'b0);
         else checks_passed++;
         if (depth !== 11'(model_q.size()))
            $display("FAIL %s idle depth: got %0d want %0d", nm, depth, model_q.size());
         else checks_passed++;
         if (stack_err !== model_err)
            $display("FAIL %s idle stack_err: got %b want %b", nm, stack_err, model_err);
         else checks_passed++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      checks_total += 2;
      if (obs !== 10'b0 || pc_next !== 16'h0 || flags_out !== 3'b0)
         $display("FAIL reset outputs: got %b %h %b want all zero", obs, pc_next, flags_out);
      else checks_passed++;
      if (depth !== 11'd0 || stack_err !== 1'b0)
         $display("FAIL reset state: got depth=%0d err=%b want 0 0", depth, stack_err);
      else checks_passed++;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      model_q.delete();
      model_err = 1'b0;
   endtask

   task automatic test_int();
      exec_op(K_INT, 16'h0040, 16'h0, 3'b101, 1'b0);
   endtask

   task automatic test_rti();
      exec_op(K_RTI, 16'h0, 16'h0, 3'b0, 1'b0);
   endtask

   task automatic test_call();
      exec_op(K_CALL, 16'h0010, 16'h0123, 3'b0, 1'b0);
   endtask

   task automatic test_ret();
      // Memory holds 0x0011 at the top of stack for this case.
      model_q[model_q.size() - 1] = 16'h0011;
      exec_op(K_RET, 16'h0, 16'h0, 3'b0, 1'b0);
   endtask

   task automatic test_underflow();
      exec_op(K_RET, 16'h0, 16'h0, 3'b0, 1'b0);
      exec_op(K_CALL, 16'h0200, 16'h0300, 3'b0, 1'b0);
      exec_op(K_RTI, 16'h0, 16'h0, 3'b0, 1'b0);
      exec_op(K_RET, 16'h0, 16'h0, 3'b0, 1'b0);
   endtask

   task automatic test_conflict();
      exec_op(K_INT, 16'h0777, 16'h0abc, 3'b011, 1'b1);
      exec_op(K_CALL, 16'h0778, 16'h0abc, 3'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++)
         exec_op(int'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                 3'($urandom), 1'b0);
   endtask

   task automatic test_reset_mid();
      int_req = 1'b1; pc = 16'h0badd; flagReg = 3'b110;
      @(posedge clk); #1;
      int_req = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      checks_total++;
      if (obs !== V_PSHCC)
         $display("FAIL rst_mid pre ctrl: got %b want %b", obs, V_PSHCC);
      else checks_passed++;
      #1 rst = 1'b1;
      #1;
      checks_total += 2;
      if (obs !== 10'b0 || pc_next !== 16'h0)
         $display("FAIL rst_mid outputs: got %b %h want zero", obs, pc_next);
      else checks_passed++;
      if (depth !== 11'd0 || stack_err !== 1'b0)
         $display("FAIL rst_mid state: got depth=%0d err=%b want 0 0", depth, stack_err);
      else checks_passed++;
      @(posedge clk); #1;
      rst = 1'b0;
      model_q.delete();
      model_err = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks_total++;
         if (obs !== 10'b0 || depth !== 11'd0)
            $display("FAIL rst_mid after c%0d: got %b depth=%0d want zero", k, obs, depth);
         else checks_passed++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_overflow();
      for (int i = 0; i < MAX_DEPTH - 2; i++)
         exec_op(K_CALL, 16'(i), 16'($urandom), 3'b0, 1'b0);
      exec_op(K_INT, 16'h1234, 16'h0, 3'b010, 1'b0);
      exec_op(K_CALL, 16'h1111, 16'h2222, 3'b0, 1'b0);
      exec_op(K_INT, 16'h5555, 16'h0, 3'b001, 1'b0);
      exec_op(K_RET, 16'h0, 16'h0, 3'b0, 1'b0);
      exec_op(K_INT, 16'h6666, 16'h0, 3'b001, 1'b0);
      exec_op(K_CALL, 16'h3333, 16'h4444, 3'b0, 1'b0);
      exec_op(K_RTI, 16'h0, 16'h0, 3'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_int();
      test_rti();
      test_call();
      test_ret();
      test_underflow();
      test_conflict();
      test_random();
      test_reset_mid();
      test_overflow();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
